// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: loads a/b on start, adds one bit per enabled cycle LSB first,
// then pulses done for one cycle with {cout,sum} = a+b. All outputs come straight from flops.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sa_nxt;
  logic [WIDTH-1:0] sb, sb_nxt;
  logic [WIDTH-1:0] sum_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             carry, carry_nxt;
  logic             cout_nxt, busy_nxt, done_nxt;

  // Full add built from two cascaded half-add steps plus the carry register.
  logic ha1_s, ha1_c, ha2_s, ha2_c, step_carry;
  assign ha1_s      = sa[0] ^ sb[0];
  assign ha1_c      = sa[0] & sb[0];
  assign ha2_s      = ha1_s ^ carry;
  assign ha2_c      = ha1_s & carry;
  assign step_carry = ha1_c | ha2_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (ena) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sa_nxt    = sa;
    sb_nxt    = sb;
    sum_nxt   = sum;
    cnt_nxt   = cnt;
    carry_nxt = carry;
    cout_nxt  = cout;
    case (state)
      IDLE: begin
        if (start) begin
          sa_nxt    = a;
          sb_nxt    = b;
          carry_nxt = 1'b0;
          cnt_nxt   = '0;
          sum_nxt   = '0;
          cout_nxt  = 1'b0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        sum_nxt   = {ha2_s, sum[WIDTH-1:1]};
        carry_nxt = step_carry;
        sa_nxt    = sa >> 1;
        sb_nxt    = sb >> 1;
        cnt_nxt   = cnt + CW'(1);
        if (cnt == LAST) begin
          cout_nxt  = step_carry;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // busy/done are registered from the next state so they stay glitch-free flop outputs.
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa    <= '0;
      sb    <= '0;
      sum   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (ena) begin
      sa    <= sa_nxt;
      sb    <= sb_nxt;
      sum   <= sum_nxt;
      cnt   <= cnt_nxt;
      carry <= carry_nxt;
      cout  <= cout_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of serial_adder_ctrl (WIDTH=8): results, latency, busy span,
// retrigger immunity, ena freeze and asynchronous reset abort.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, ena, start;
  logic [7:0] a, b;
  logic       busy, done, cout;
  logic [7:0] sum;

  int checks = 0;
  int errors = 0;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
    .a(a), .b(b), .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts one add and follows it to done. Edge count is taken from the accepting edge;
  // done appears after edge E0+8, i.e. in the 9th cycle counting the start cycle.
  task automatic add_check(input logic [7:0] ta, input logic [7:0] tb_v,
                           input logic [8:0] exp, input bit full, input string tag);
    int lat;
    int busy_cnt;
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_cnt = busy ? 1 : 0;
    lat = 0;
    while (!done && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_cnt++;
    end
    chk({cout, sum}, exp, {tag, "_result"});
    if (full) begin
      chk(lat, 8, {tag, "_latency"});
      chk(busy_cnt, 9, {tag, "_busy_span"});
      @(posedge clk); #1;
      chk({busy, done}, 2'b00, {tag, "_done_pulse_end"});
    end else begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int lat;
    int pulses;
    logic [7:0] ra, rb, held;
    logic [8:0] got;

    rst_n = 1'b0; ena = 1'b1; start = 1'b0; a = '0; b = '0;
    #12;
    chk(busy, 0, "rst_busy");
    chk(done, 0, "rst_done");
    chk(sum, 0, "rst_sum");
    chk(cout, 0, "rst_cout");
    @(negedge clk); rst_n = 1'b1;

    add_check(8'h00, 8'h00, 9'h000, 1'b1, "zero");
    add_check(8'hFF, 8'h01, 9'h100, 1'b1, "ripple");
    add_check(8'hA5, 8'h5A, 9'h0FF, 1'b1, "alt");
    add_check(8'hFF, 8'hFF, 9'h1FE, 1'b1, "max");

    // Retrigger three cycles in with new operands: must be ignored.
    @(negedge clk); a = 8'h12; b = 8'h34; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    pulses = 0; got = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) begin pulses++; got = {cout, sum}; end
    end
    chk(pulses, 1, "retrig_pulses");
    chk(got, 9'h046, "retrig_result");

    // ena low for four edges after three steps: done slips by four edges.
    @(negedge clk); a = 8'h0F; b = 8'h01; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    lat = 0; held = '0;
    while (!done && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 3) begin held = sum; ena = 1'b0; end
      if (lat == 7) begin
        chk(sum, held, "freeze_sum_hold");
        chk(busy, 1, "freeze_busy_hold");
        ena = 1'b1;
      end
    end
    chk(lat, 12, "freeze_latency");
    chk({cout, sum}, 9'h010, "freeze_result");
    @(posedge clk); #1;

    // Async reset four steps into A5+5A (partial sum F0).
    @(negedge clk); a = 8'hA5; b = 8'h5A; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk(sum, 8'hF0, "abort_partial_sum");
    rst_n = 1'b0;
    #1;
    chk(busy, 0, "abort_busy");
    chk(sum, 0, "abort_sum");
    chk(cout, 0, "abort_cout");
    chk(done, 0, "abort_done");
    @(negedge clk); rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk(pulses, 0, "abort_no_done");

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      add_check(ra, rb, {1'b0, ra} + {1'b0, rb}, (i < 20), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
